// File: rtl/crc32_chk.sv
// Receive-side CRC-32 checker: refolds a latched frame CHUNK_WIDTH bits per cycle,
// compares against the received checksum and keeps a saturating failed-frame count.
module crc32_chk #(
    parameter int DATA_WIDTH    = 512,
    parameter int CRC_WIDTH     = 32,
    parameter int CHUNK_WIDTH   = 64,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [CRC_WIDTH-1:0]     checksum_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     crc_err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [31:0]      POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_INIT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reflected CRC-32 update over one chunk, byte 0 (lowest bits) first.
    function automatic logic [31:0] crc_fold(input logic [31:0] crc,
                                             input logic [CHUNK_WIDTH-1:0] chunk);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < CHUNK_WIDTH / 8; k++) begin
            c = c ^ {24'h00_0000, chunk[8*k +: 8]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    state_t                                   state_r;
    state_t                                   state_s;
    logic [CNT_W-1:0]                         cnt_r;
    logic [31:0]                              crc_r;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0]   data_r;
    logic [CRC_WIDTH-1:0]                     checksum_r;
    logic                                     ready_r;
    logic                                     valid_r;
    logic                                     crc_err_r;
    logic [ERR_CNT_WIDTH-1:0]                 err_cnt_r;

    logic [31:0] crc_next_s;
    logic        last_s;
    logic        mismatch_s;
    logic        accept_s;

    assign crc_next_s = crc_fold(crc_r, data_r[cnt_r]);
    assign last_s     = (cnt_r == LAST_CNT);
    // Final XOR, then bit-reverse into the encoder's checksum orientation.
    assign mismatch_s = (reflect32(crc_next_s ^ CRC_INIT) != checksum_r);
    assign accept_s   = valid_i & ready_r & (state_r == IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CALC;
                else          state_s = IDLE;
            end
            CALC: begin
                if (last_s) state_s = DONE;
                else        state_s = CALC;
            end
            DONE: begin
                if (ready_i) state_s = IDLE;
                else         state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            crc_r      <= CRC_INIT;
            data_r     <= {DATA_WIDTH{1'b0}};
            checksum_r <= {CRC_WIDTH{1'b0}};
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            crc_err_r  <= 1'b0;
            err_cnt_r  <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r     <= data_i;
                        checksum_r <= checksum_i;
                        crc_r      <= CRC_INIT;
                        cnt_r      <= {CNT_W{1'b0}};
                        ready_r    <= 1'b0;
                    end
                end
                CALC: begin
                    crc_r <= crc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        crc_err_r <= mismatch_s;
                        valid_r   <= 1'b1;
                        // Counter sticks at all-ones rather than wrapping.
                        if (mismatch_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
                            err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o   = ready_r;
    assign valid_o   = valid_r;
    assign data_o    = data_r;
    assign crc_err_o = crc_err_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_crc32_chk.sv
// Self-checking bench for crc32_chk: vector table plus scoreboard queue, with
// hand-written backpressure, mid-frame reset and counter saturation sequences.
module tb_crc32_chk;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_i;
    logic [511:0] data_i;
    logic [31:0]  checksum_i;

    logic         ready_o, valid_o, crc_err_o;
    logic [511:0] data_o;
    logic [15:0]  err_cnt_o;

    logic         ready2, valid2, err2;
    logic [511:0] data2;
    logic [1:0]   cnt2;

    crc32_chk dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .checksum_i(checksum_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .crc_err_o(crc_err_o),
        .err_cnt_o(err_cnt_o)
    );

    crc32_chk #(.ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready2),
        .data_i(data_i), .checksum_i(checksum_i), .valid_o(valid2),
        .ready_i(ready_i), .data_o(data2), .crc_err_o(err2),
        .err_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] data;
        logic         err;
        logic [15:0]  c16;
        logic [1:0]   c2;
        int           acc;
    } sb_t;

    typedef struct {
        logic [511:0] data;
        int           flip;
        logic         exp_err;
    } vec_t;

    sb_t         q[$];
    sb_t         mon_e;
    logic        prev_v = 1'b0;
    logic [15:0] m16 = 16'd0;
    logic [1:0]  m2  = 2'd0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Standard CRC-32 over the first nbytes bytes, one bit at a time.
    function automatic logic [31:0] crc_std(input logic [511:0] d, input int nbytes);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes * 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return ~c;
    endfunction

    function automatic logic [31:0] enc(input logic [511:0] d);
        logic [31:0] s, r;
        s = crc_std(d, 64);
        for (int i = 0; i < 32; i++) r[i] = s[31-i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Present a frame, wait (bounded) for acceptance, push the expectation.
    task automatic drive(input logic [511:0] d, input logic [31:0] c, input logic e,
                         output int acc);
        int  n;
        sb_t s;
        n = 0;
        valid_i = 1'b1;
        data_i = d;
        checksum_i = c;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_int("accept_timeout", int'(n < 200), 1);
        @(negedge clk);
        acc = cyc;
        if (e) begin
            if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
            if (m2 != 2'd3) m2 = m2 + 2'd1;
        end
        s.data = d; s.err = e; s.c16 = m16; s.c2 = m2; s.acc = acc;
        q.push_back(s);
        valid_i = 1'b0;
        data_i = rand512();
        checksum_i = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_int("drain_timeout", q.size(), 0);
    endtask

    // Output monitor, sampled mid-way between the negative and positive edges.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (valid_o && !prev_v) begin
                chk_int("valid_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) chk_int("latency", cyc - q[0].acc, 8);
            end
            if (valid_o && ready_i && q.size() != 0) begin
                mon_e = q.pop_front();
                chk("data_o", data_o, mon_e.data);
                chk_int("crc_err_o", int'(crc_err_o), int'(mon_e.err));
                chk_int("err_cnt_o", int'(err_cnt_o), int'(mon_e.c16));
                chk_int("dut2_valid", int'(valid2), 1);
                chk("dut2_data", data2, mon_e.data);
                chk_int("dut2_err_cnt", int'(cnt2), int'(mon_e.c2));
            end
            prev_v = valid_o;
        end
    end

    initial begin
        vec_t         vecs[13];
        logic [511:0] d, a, b;
        logic [31:0]  c;
        logic [511:0] kat;
        string        s;
        int           acc, accb, rel, nv;

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        data_i = '0; checksum_i = 32'h0;

        s = "123456789";
        kat = '0;
        for (int k = 0; k < 9; k++) kat[8*k +: 8] = s[k];
        if (crc_std(kat, 9) != 32'hCBF4_3926) begin
            $display("FAIL model_kat: got %h expected cbf43926", crc_std(kat, 9));
            $fatal(1, "reference model broken");
        end

        repeat (3) @(negedge clk);
        chk_int("rst_ready", int'(ready_o), 1);
        chk_int("rst_valid", int'(valid_o), 0);
        chk_int("rst_err", int'(crc_err_o), 0);
        chk("rst_data", data_o, 512'd0);
        chk_int("rst_cnt", int'(err_cnt_o), 0);
        chk_int("rst_ready2", int'(ready2), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_int("post_rst_ready", int'(ready_o), 1);
        chk_int("post_rst_valid", int'(valid_o), 0);

        // Vector table: 10 clean frames, then data bit 0, data bit 511, checksum bit 31.
        for (int i = 0; i < 13; i++) begin
            vecs[i].data = rand512();
            vecs[i].flip = -1;
            vecs[i].exp_err = 1'b0;
        end
        vecs[10].flip = 0;   vecs[10].exp_err = 1'b1;
        vecs[11].flip = 511; vecs[11].exp_err = 1'b1;
        vecs[12].flip = 543; vecs[12].exp_err = 1'b1;

        for (int i = 0; i < 13; i++) begin
            d = vecs[i].data;
            c = enc(d);
            if (vecs[i].flip >= 0 && vecs[i].flip < 512) d[vecs[i].flip] = ~d[vecs[i].flip];
            if (vecs[i].flip >= 512) c[vecs[i].flip - 512] = ~c[vecs[i].flip - 512];
            drive(d, c, vecs[i].exp_err, acc);
        end
        wait_drain();
        chk_int("cnt_after_corrupt", int'(err_cnt_o), 3);

        // Backpressure: stall DONE for 20 cycles while the next frame waits.
        ready_i = 1'b0;
        a = rand512();
        b = rand512();
        rel = 0;
        accb = 0;
        drive(a, enc(a), 1'b0, acc);
        fork
            begin
                nv = 0;
                while (!valid_o && nv < 50) begin
                    @(negedge clk);
                    nv++;
                end
                chk_int("bp_valid_seen", int'(valid_o), 1);
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk_int("bp_ready_low", int'(ready_o), 0);
                    chk_int("bp_valid_high", int'(valid_o), 1);
                    chk("bp_data_hold", data_o, a);
                    chk_int("bp_err_hold", int'(crc_err_o), 0);
                    chk_int("bp_cnt_hold", int'(err_cnt_o), 3);
                end
                rel = cyc;
                ready_i = 1'b1;
            end
            begin
                drive(b, enc(b), 1'b0, accb);
            end
        join
        chk_int("bp_second_accept", accb - rel, 2);
        wait_drain();

        // Reset during CALC chunk 4.
        drive(rand512(), 32'h0, 1'b1, acc);
        repeat (4) @(negedge clk);
        chk_int("pre_rst_ready", int'(ready_o), 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        m16 = 16'd0;
        m2 = 2'd0;
        #1;
        chk_int("async_valid", int'(valid_o), 0);
        chk_int("async_ready", int'(ready_o), 1);
        chk_int("async_cnt", int'(err_cnt_o), 0);
        chk_int("async_cnt2", int'(cnt2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid_o) nv++;
        end
        chk_int("no_valid_after_rst", nv, 0);
        d = rand512();
        drive(d, enc(d), 1'b0, acc);
        wait_drain();

        // Saturation of the 2-bit counter across 5 corrupted frames.
        for (int i = 0; i < 5; i++) begin
            d = rand512();
            c = enc(d);
            d[i * 97] = ~d[i * 97];
            drive(d, c, 1'b1, acc);
        end
        wait_drain();
        chk_int("sat_cnt2_final", int'(cnt2), 3);
        chk_int("sat_cnt16_final", int'(err_cnt_o), 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/crc32_chk.md
Name: crc32_chk

Overview:
- Receive-side CRC32 checker. Sits directly downstream of CRC32_ENC and consumes its data/checksum pair.
- Recomputes CRC32 over a 512-bit frame iteratively, CHUNK_WIDTH bits per cycle.
- Compares the result with the received checksum, then forwards the data with a pass/fail flag.
- Keeps a saturating count of failed frames for link-health monitoring.

Parameters:
- DATA_WIDTH, 512, frame width in bits; must be a multiple of CHUNK_WIDTH.
- CRC_WIDTH, 32, checksum width; only 32 is supported.
- CHUNK_WIDTH, 64, bits folded into the CRC per cycle; multiple of 8.
- ERR_CNT_WIDTH, 16, width of the failed-frame counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  frame valid from upstream.
- ready_o  output  1  checker can accept a frame.
- data_i  input  DATA_WIDTH  frame payload.
- checksum_i  input  CRC_WIDTH  received checksum, same bit orientation as CRC32_ENC checksum_o.
- valid_o  output  1  checked frame available.
- ready_i  input  1  downstream accepts the frame.
- data_o  output  DATA_WIDTH  registered copy of the accepted payload.
- crc_err_o  output  1  1 = recomputed CRC differs from checksum_i; valid only while valid_o=1.
- err_cnt_o  output  ERR_CNT_WIDTH  saturating count of frames with crc_err_o=1.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, ready_o=1, valid_o=0, crc_err_o=0, data_o=0, err_cnt_o=0.
  - Chunk counter = 0, CRC register = 0xFFFFFFFF.
  - An in-flight frame is discarded, with no output and no count.
- CRC algorithm: CRC-32, poly 0x04C11DB7, reflected (LSB-first) input and output, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Byte k = data_i[8k+7:8k], processed in order k=0 first.
  - Each CHUNK_WIDTH slice is folded as one combinational step equal to CHUNK_WIDTH/8 serial byte updates.
  - The final reflected CRC is bit-reversed before comparison: checksum_i[i] corresponds to standard CRC bit [31-i], matching CRC32_ENC output.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready_o=1. On valid_i & ready_o, latch data_i and checksum_i, set CRC register = 0xFFFFFFFF and chunk counter = 0, go to CALC.
  - CALC: ready_o=0. Each cycle fold chunk [cnt*CHUNK_WIDTH +: CHUNK_WIDTH] and increment cnt. On the last chunk (cnt = DATA_WIDTH/CHUNK_WIDTH-1), register crc_err_o, go to DONE. No early exit.
  - DONE: valid_o=1; data_o and crc_err_o held stable until ready_i=1.
    - On valid_o & ready_i, go to IDLE, valid_o=0 next cycle.
    - err_cnt_o increments by 1 on entry to DONE when the error is set, saturating at all-ones with no wrap.
- Latency: valid_o rises exactly NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH cycles (8 at defaults) after the accepting edge.
  - Minimum frame period is NUM_CHUNKS+2 = 10 cycles (accept, 8 CALC, DONE with ready_i=1).
- ready_o is 0 in CALC and DONE. valid_i there is ignored and upstream must hold its frame. No frame drop or overwrite occurs.
- data_i/checksum_i changes after acceptance have no effect on the frame in flight.
- ready_i is ignored outside DONE.
- Backpressure: DONE may persist indefinitely; err_cnt_o is not re-incremented while stalled.

Test Plan:
- Back-to-back with CRC32_ENC:
  - Drive 10 random 512-bit frames through CRC32_ENC, feed data_o/checksum_o into this block with ready_i=1.
  - Required: each frame gives crc_err_o=0, data_o equal to the input, valid_o exactly 8 cycles after accept, err_cnt_o=0.
- Single-bit corruption:
  - Encoder-produced pair with data_i bit 0 flipped; repeat with bit 511, then with checksum_i bit 31.
  - Required: crc_err_o=1 each time, err_cnt_o steps 1, 2, 3.
- Backpressure:
  - Hold ready_i=0 for 20 cycles after valid_o rises while upstream keeps valid_i=1 with a new frame.
  - Required: ready_o=0 throughout, data_o/crc_err_o stable, err_cnt_o unchanged.
  - Second frame accepted in the first IDLE cycle after ready_i=1.
- Reset mid-operation:
  - Assert rst_n=0 at CALC chunk 4.
  - Required: valid_o=0 and ready_o=1 immediately (asynchronous), err_cnt_o=0, no valid_o pulse.
  - The next frame checks correctly.
- Counter saturation (bench sets ERR_CNT_WIDTH=2):
  - Send 5 corrupted frames.
  - Required: err_cnt_o reads 1, 2, 3, 3, 3.
